mc_cpu_core: RTL and testbench
==============================

# mc_cpu_core

Multi-cycle MIPS-subset processor core; the parametrised successor to the single-cycle CPU. Instructions run through a per-instruction FSM over one shared instruction/data memory port with a request/ready handshake, so memory may insert wait states. Adds data memory access (lw/sw), bne, j, slti, illegal-instruction halt and an optional alignment check. Sits between the testbench memory model and the existing ALU/register-file conventions.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ALIGN_CHECK, 1: 1 = misaligned lw/sw address halts the core; 0 = address low 2 bits forced to 00.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write (sw), 0 = read.
- mem_addr_o  out  32  byte address, always word aligned.
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  read data, valid in the cycle mem_req_o & mem_ready_i.
- mem_ready_i  in  1  completes the current request.
- pc_o  out  32  PC of the instruction in progress.
- retire_o  out  1  one-cycle pulse when an instruction completes.
- halted_o  out  1  core halted (sticky until reset).

## Operation
- Reset (rst_i=0): PC=RESET_PC, state FETCH, all 32 registers 0, IR 0; mem_req_o, mem_we_o, retire_o, halted_o = 0; mem_addr_o, mem_wdata_o = 0. Reset mid-transaction abandons it immediately.
- Supported: R-type (op 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08, slti 0x0A (sign-extended imm); beq 0x04, bne 0x05; lw 0x23, sw 0x2B; j 0x02.
- Any other opcode, or R-type with other funct -> HALT, no architectural state change.
- Arithmetic 32-bit wrap-around, no overflow trap. Register $0 reads 0; writes to it discarded.
- Branch target = PC+4 + (sext(imm)<<2); jump target = {PC+4[31:28], instr[25:0], 2'b00}.
- Load/store address = rs + sext(imm). Misaligned (addr[1:0]≠0): ALIGN_CHECK=1 -> HALT without issuing the access; ALIGN_CHECK=0 -> addr[1:0] masked.
- States:
  - FETCH: mem_req_o=1, we=0, addr=PC; on ready latch IR, PC<=PC+4, go DECODE.
  - DECODE: read rs/rt, sign-extend; illegal -> HALT, else EXEC.
  - EXEC: ALU op. beq/bne/j: update PC if taken, retire, go FETCH. lw/sw: compute address, go MEM. Others: go WB.
  - MEM: mem_req_o=1, we=1 for sw with wdata=rt. On ready: sw retires -> FETCH; lw latches rdata -> WB.
  - WB: write rd (R-type) / rt (I-type, lw); retire; go FETCH.
  - HALT: halted_o=1, mem_req_o=0, no further state change until reset.
- pc_o reports the address of the current instruction; it is frozen at the faulting instruction in HALT.

## Timing
- Handshake: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o stable from assertion until the cycle where mem_ready_i=1 is sampled; request drops the following cycle unless a new one starts. Ready while req=0 ignored. Zero-wait memory = ready high in the same cycle as req.
- Cycles per instruction at zero wait: branch/j 3, R-type/addi/slti 4, sw 4, lw 5. Each memory wait cycle adds 1.
- retire_o pulses in the last cycle of the instruction; register write and PC update visible next cycle.
- Back-to-back: FETCH of the next instruction starts the cycle after retire.
- halted_o rises the cycle after DECODE (or EXEC on misalignment) detects the fault.

## Test plan
- Reset: hold rst_i=0 with mem_ready_i=1 -> all outputs 0; release -> FETCH at RESET_PC=0x100, mem_addr_o=0x100.
- ALU sequence: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1 -> $3=2, $4=1, $5=0xFFFFFFF8; retire spacing 4 cycles.
- Memory with 2 wait cycles: sw $3,8($0) then lw $6,8($0) -> write addr 0x8 data 2 held 3 cycles; $6=2; lw takes 9 cycles total.
- Control flow: beq taken (offset +2) skips 2 words; bne not taken falls to PC+4; j 0x40 -> next fetch addr 0x100; each 3 cycles; write to $0 leaves it 0.
- Misaligned lw addr 0x6 with ALIGN_CHECK=1 -> no memory request, halted_o=1, pc_o=lw address; ALIGN_CHECK=0 -> read issued at 0x4.
- Illegal opcode 0x3F and reset asserted during a 5-cycle-stalled fetch -> HALT held, mem_req_o=0; reset returns to FETCH at RESET_PC, halted_o=0.

Source files
------------

// File: rtl/mc_cpu_core_if.sv
// mc_cpu_core_if: shared instruction/data memory bus with request/ready handshake
interface mc_cpu_core_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle MIPS-subset core sharing one memory port for fetch and data
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mc_cpu_core_if.master mem,
    output logic [31:0]   pc_o,
    output logic          retire_o,
    output logic          halted_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_sel;
    logic [31:0] imm_sx, opb, sum, diff, alu_res, pc_plus4, br_tgt, j_tgt, flow_tgt;
    logic        is_r, is_flow, is_ldst, is_sw, legal, lt, taken, ea_ok, ready, req, we;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_r     = op == OP_R;
    assign is_sw    = op == OP_SW;
    assign is_flow  = op inside {OP_BEQ, OP_BNE, OP_J};
    assign is_ldst  = op inside {OP_LW, OP_SW};
    assign legal    = is_r ? (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})
                           : (op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW});
    assign opb      = is_r ? b_q : imm_sx;
    assign sum      = a_q + opb;
    assign diff     = a_q - opb;
    assign lt       = $signed(a_q) < $signed(opb);
    assign alu_res  = !is_r ? (op == OP_SLTI ? {31'b0, lt} : sum)
                    : funct == F_SUB ? diff
                    : funct == F_AND ? (a_q & b_q)
                    : funct == F_OR  ? (a_q | b_q)
                    : funct == F_SLT ? {31'b0, lt} : sum;
    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {imm_sx[29:0], 2'b00};
    assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign taken    = op == OP_J || (op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q);
    assign flow_tgt = !taken ? pc_plus4 : op == OP_J ? j_tgt : br_tgt;
    assign ea_ok    = !ALIGN_CHECK || sum[1:0] == 2'b00;
    assign wr_sel   = is_r ? rd : rt;
    assign ready    = mem.mem_ready_i;

    // Reset gates the bus outputs so nothing is requested while rst_i is low
    assign req             = rst_i && (state_q == S_FETCH || state_q == S_MEM);
    assign we              = rst_i && state_q == S_MEM && is_sw;
    assign mem.mem_req_o   = req;
    assign mem.mem_we_o    = we;
    assign mem.mem_addr_o  = !req ? '0 : state_q == S_FETCH ? pc_q : res_q;
    assign mem.mem_wdata_o = we ? b_q : '0;
    assign retire_o        = (state_q == S_EXEC && is_flow) || (state_q == S_MEM && ready && is_sw)
                           || state_q == S_WB;
    assign halted_o        = state_q == S_HALT;
    assign pc_o            = pc_q;

    // Next-state and datapath sequencing; pc_q holds the current instruction until it retires
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = ready ? mem.mem_rdata_i : ir_q;
                state_d = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                pc_d    = is_flow ? flow_tgt : pc_q;
                res_d   = is_ldst ? {sum[31:2], 2'b00} : alu_res;
                state_d = is_flow ? S_FETCH : !is_ldst ? S_WB : ea_ok ? S_MEM : S_HALT;
            end
            S_MEM: begin
                pc_d    = (ready && is_sw) ? pc_plus4 : pc_q;
                res_d   = (ready && !is_sw) ? mem.mem_rdata_i : res_q;
                state_d = !ready ? S_MEM : is_sw ? S_FETCH : S_WB;
            end
            S_WB: begin
                pc_d    = pc_plus4;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (state_q == S_WB && wr_sel != 5'd0) begin
            rf_q[wr_sel] <= res_q;
        end
    end
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: random-wait memory, random program block, instruction-level reference model
module tb_mc_cpu_core;
    localparam logic [31:0] RPC = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_cpu_core_if bus ();
    mc_cpu_core_if bus2 ();
    logic [31:0] pc, pc2;
    logic        ret, ret2, hlt, hlt2;

    mc_cpu_core #(.RESET_PC(RPC), .ALIGN_CHECK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_n), .mem(bus), .pc_o(pc), .retire_o(ret), .halted_o(hlt));
    mc_cpu_core #(.RESET_PC(RPC), .ALIGN_CHECK(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .mem(bus2), .pc_o(pc2), .retire_o(ret2), .halted_o(hlt2));

    logic [31:0] ram [1024];
    logic [31:0] mm [1024];
    logic [31:0] mr [32];
    logic [31:0] mpc;
    logic [31:0] mem2 [128];
    int n_chk = 0, n_pass = 0, n_ret = 0, fixed_w = -1;
    int cyc_log [64];
    int wp;
    logic [31:0] mis_pc;
    logic [31:0] rd2_addr = '1, st2_addr = '1, st2_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] w);
        ram[wp] = w;
        mm[wp] = w;
        wp++;
    endtask

    // One architectural instruction: returns halt flag, zero-wait cycle cost, and any store
    task automatic model_step(output bit h, output int base, output bit st,
                              output logic [31:0] sa, output logic [31:0] sd);
        logic [31:0] ins, a, b, im, res, ea, np;
        logic [5:0] op, fn;
        int dst;
        ins = mm[mpc[11:2]];
        op = ins[31:26];
        fn = ins[5:0];
        im = {{16{ins[15]}}, ins[15:0]};
        a = mr[ins[25:21]];
        b = mr[ins[20:16]];
        np = mpc + 4;
        h = 0; st = 0; sa = 0; sd = 0; base = 4; dst = 0; res = 0; ea = a + im;
        case (op)
            6'h00: begin
                dst = int'(ins[15:11]);
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin h = 1; base = 3; end
                endcase
            end
            6'h08: begin dst = int'(ins[20:16]); res = a + im; end
            6'h0A: begin dst = int'(ins[20:16]); res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0; end
            6'h04: begin base = 3; if (a == b) np = mpc + 4 + (im << 2); end
            6'h05: begin base = 3; if (a != b) np = mpc + 4 + (im << 2); end
            6'h02: begin base = 3; np = {np[31:28], ins[25:0], 2'b00}; end
            6'h23: begin
                if (ea[1:0] != 0) h = 1;
                else begin dst = int'(ins[20:16]); res = mm[ea[11:2]]; base = 5; end
            end
            6'h2B: begin
                if (ea[1:0] != 0) h = 1;
                else begin st = 1; sa = ea; sd = b; mm[ea[11:2]] = b; end
            end
            default: begin h = 1; base = 3; end
        endcase
        if (!h) begin
            if (dst != 0) mr[dst] = res;
            mpc = np;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_halt(input int lim);
        int i = 0;
        while (!hlt && i < lim) begin tick(); i++; end
        chk("halt_reached", 32'(hlt), 32'd1);
    endtask

    // Memory responder for the main core: wait states per request, random ready when idle
    int w = 0;
    bit busy = 0;
    initial begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.mem_req_o) begin
                busy = 0;
                bus.mem_ready_i = !rst_n ? 1'b1 : 1'($urandom_range(0, 1));
                bus.mem_rdata_i = $urandom;
            end else begin
                if (!busy) begin
                    busy = 1;
                    w = fixed_w >= 0 ? fixed_w : n_ret < 12 ? 0 : n_ret < 14 ? 2 : int'($urandom_range(0, 3));
                end
                if (w == 0) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = ram[bus.mem_addr_o[11:2]];
                    if (bus.mem_we_o) ram[bus.mem_addr_o[11:2]] = bus.mem_wdata_o;
                    busy = 0;
                end else begin
                    bus.mem_ready_i = 1'b0;
                    bus.mem_rdata_i = $urandom;
                    w--;
                end
            end
        end
    end

    // Zero-wait responder for the core built without the alignment check
    initial begin
        bus2.mem_ready_i = 1'b1;
        bus2.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus2.mem_rdata_i = mem2[bus2.mem_addr_o[8:2]];
            if (rst_n && bus2.mem_req_o && bus2.mem_we_o) begin
                st2_addr = bus2.mem_addr_o;
                st2_data = bus2.mem_wdata_o;
            end
            if (rst_n && bus2.mem_req_o && !bus2.mem_we_o && bus2.mem_addr_o < RPC) rd2_addr = bus2.mem_addr_o;
        end
    end

    // Per-cycle comparison of the main core against the reference model
    bit mh, ms, pend, was_h;
    int mbase, cyc, waits, dreq;
    logic [31:0] msa, msd, p_addr, p_wdata;
    logic p_we;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mpc = RPC;
                for (int i = 0; i < 32; i++) mr[i] = '0;
                cyc = 0; waits = 0; dreq = 0; pend = 0; was_h = 0;
            end else begin
                cyc++;
                if (bus.mem_req_o && !bus.mem_ready_i) waits++;
                if (bus.mem_req_o && bus.mem_addr_o != pc) dreq++;
                if (pend) begin
                    chk("hold_req", 32'(bus.mem_req_o), 32'd1);
                    chk("hold_addr", bus.mem_addr_o, p_addr);
                    chk("hold_we", 32'(bus.mem_we_o), 32'(p_we));
                    chk("hold_wdata", bus.mem_wdata_o, p_wdata);
                end
                pend = bus.mem_req_o && !bus.mem_ready_i;
                p_addr = bus.mem_addr_o;
                p_we = bus.mem_we_o;
                p_wdata = bus.mem_wdata_o;
                if (hlt) begin
                    if (!was_h) begin
                        chk("halt_pc", pc, mpc);
                        model_step(mh, mbase, ms, msa, msd);
                        chk("halt_expected", 32'(mh), 32'd1);
                        chk("halt_cycles", cyc, mbase + waits);
                        chk("halt_no_data_req", dreq, 0);
                        was_h = 1;
                    end else begin
                        chk("halt_quiet", {30'b0, bus.mem_req_o, ret}, 32'd0);
                        chk("halt_pc_frozen", pc, mpc);
                    end
                end else if (ret) begin
                    if (n_ret < 64) cyc_log[n_ret] = cyc;
                    chk("retire_pc", pc, mpc);
                    model_step(mh, mbase, ms, msa, msd);
                    chk("retire_legal", 32'(mh), 32'd0);
                    chk("retire_cycles", cyc, mbase + waits);
                    if (ms) begin
                        chk("store_we", 32'(bus.mem_we_o), 32'd1);
                        chk("store_addr", bus.mem_addr_o, msa);
                        chk("store_data", bus.mem_wdata_o, msd);
                    end
                    n_ret++;
                    cyc = 0; waits = 0; dreq = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin ram[i] = '0; mm[i] = '0; end
        for (int i = 32; i < 64; i++) begin v = $urandom; ram[i] = v; mm[i] = v; end
        for (int i = 0; i < 128; i++) mem2[i] = '0;
        mem2[1]  = 32'hCAFE_F00D;
        mem2[64] = enc_i(6'h23, 5'd0, 5'd1, 16'h0006);
        mem2[65] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);
        mem2[66] = 32'hFC00_0000;
        wp = 64;
        put(enc_i(6'h08, 5'd7, 5'd7, 16'd1));
        put(enc_i(6'h08, 5'd0, 5'd8, 16'd2));
        put(enc_i(6'h04, 5'd7, 5'd8, 16'd1));
        put({6'h02, 26'h40});
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        put(enc_r(5'd2, 5'd1, 5'd5, 6'h22));
        put(enc_i(6'h2B, 5'd0, 5'd3, 16'd8));
        put(enc_i(6'h23, 5'd0, 5'd6, 16'd8));
        put(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        put(enc_i(6'h08, 5'd0, 5'd9, 16'd1));
        put(enc_i(6'h08, 5'd0, 5'd9, 16'd2));
        put(enc_i(6'h05, 5'd0, 5'd0, 16'd5));
        put(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        put(enc_i(6'h2B, 5'd0, 5'd0, 16'd12));
        put(enc_i(6'h2B, 5'd0, 5'd4, 16'd16));
        put(enc_i(6'h2B, 5'd0, 5'd5, 16'd20));
        put(enc_i(6'h2B, 5'd0, 5'd6, 16'd24));
        put(enc_i(6'h2B, 5'd0, 5'd9, 16'd28));
        for (int k = 0; k < 60; k++) begin
            automatic int sel = $urandom_range(0, 7);
            automatic logic [4:0] ra = 5'($urandom_range(0, 15));
            automatic logic [4:0] rb = 5'($urandom_range(0, 15));
            automatic logic [4:0] rc = 5'($urandom_range(0, 15));
            automatic logic [15:0] off = 16'((32 + $urandom_range(0, 31)) * 4);
            case (sel)
                0: put(enc_r(ra, rb, rc, 6'h20));
                1: put(enc_r(ra, rb, rc, 6'h22));
                2: put(enc_r(ra, rb, rc, 6'h24));
                3: put(enc_r(ra, rb, rc, 6'h25));
                4: put(enc_r(ra, rb, rc, 6'h2A));
                5: put(enc_i(6'h08, ra, rb, 16'($urandom)));
                6: put(enc_i(6'h0A, ra, rb, 16'($urandom)));
                default: put(enc_i($urandom_range(0, 1) ? 6'h2B : 6'h23, 5'd0, rb, off));
            endcase
        end
        for (int r = 1; r < 16; r++) put(enc_i(6'h2B, 5'd0, 5'(r), 16'((7 + r) * 4)));
        mis_pc = 32'(wp * 4);
        put(enc_i(6'h23, 5'd0, 5'd10, 16'd6));

        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_retire", 32'(ret), 32'd0);
        chk("rst_halted", 32'(hlt), 32'd0);
        chk("rst_pc", pc, RPC);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("first_fetch_req", 32'(bus.mem_req_o), 32'd1);
        chk("first_fetch_addr", bus.mem_addr_o, RPC);
        wait_halt(8000);
        repeat (3) tick();
        chk("misalign_pc", pc, mis_pc);
        chk("misalign_req", 32'(bus.mem_req_o), 32'd0);
        chk("model_sw_word", mm[2], 32'd2);
        chk("model_zero_reg", mm[3], 32'd0);
        chk("model_slt", mm[4], 32'd1);
        chk("model_sub", mm[5], 32'hFFFF_FFF8);
        chk("model_lw", mm[6], 32'd2);
        chk("model_skip", mm[7], 32'd0);
        chk("cyc_first_addi", cyc_log[0], 4);
        chk("cyc_beq_nt", cyc_log[2], 3);
        chk("cyc_j", cyc_log[3], 3);
        chk("cyc_beq_t", cyc_log[6], 3);
        chk("cyc_add", cyc_log[9], 4);
        chk("cyc_sw_2wait", cyc_log[12], 8);
        chk("cyc_lw_2wait", cyc_log[13], 9);
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), ram[i], mm[i]);
        chk("noalign_halted", 32'(hlt2), 32'd1);
        chk("noalign_read_addr", rd2_addr, 32'h4);
        chk("noalign_store_addr", st2_addr, 32'h20);
        chk("noalign_store_data", st2_data, 32'hCAFE_F00D);
        chk("noalign_pc", pc2, RPC + 32'h8);

        ram[64] = 32'hFC00_0000;
        mm[64] = 32'hFC00_0000;
        fixed_w = 5;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        chk("stall_req", 32'(bus.mem_req_o), 32'd1);
        chk("stall_ready", 32'(bus.mem_ready_i), 32'd0);
        chk("stall_addr", bus.mem_addr_o, RPC);
        @(posedge clk);
        #1 rst_n = 1'b0;
        tick();
        chk("midrst_req", 32'(bus.mem_req_o), 32'd0);
        chk("midrst_addr", bus.mem_addr_o, 32'd0);
        chk("midrst_halted", 32'(hlt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("refetch_req", 32'(bus.mem_req_o), 32'd1);
        chk("refetch_addr", bus.mem_addr_o, RPC);
        wait_halt(200);
        repeat (4) tick();
        chk("illegal_pc", pc, RPC);
        chk("illegal_req", 32'(bus.mem_req_o), 32'd0);
        chk("illegal_halted", 32'(hlt), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        tick();
        chk("final_rst_halted", 32'(hlt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("final_fetch_req", 32'(bus.mem_req_o), 32'd1);
        chk("final_fetch_addr", bus.mem_addr_o, RPC);
        chk("final_halted", 32'(hlt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
